// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder
//   Packs RV32I instruction fields into 32-bit words and streams them, with a
//   word address, toward an instruction-memory write port. It is the encode
//   side of the decoder: the loader/self-test logic hands over fields, and
//   this block emits encoded words one cycle later.
//
//   Ports
//     CLK, rst             clock; synchronous active-high reset
//     addr_load, addr_val  load the word-address counter (wins over increment)
//     in_valid/in_ready    request handshake; in_ready is registered
//     in_fmt               0=R 1=I 2=S 3=B 4=U 5=J (6,7 illegal)
//     in_opcode/funct3/funct7/rd/rs1/rs2/imm  instruction fields
//     out_valid/out_ready  encoded-word handshake
//     out_instr, out_addr  encoded word and its word address
//     out_err              request was illegal; out_instr carries a NOP
//     word_cnt, err_cnt    saturating counts of emitted / illegal words
module rv32i_instr_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_val,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [2:0]  FMT_R = 3'd0;
    localparam logic [2:0]  FMT_I = 3'd1;
    localparam logic [2:0]  FMT_S = 3'd2;
    localparam logic [2:0]  FMT_B = 3'd3;
    localparam logic [2:0]  FMT_U = 3'd4;
    localparam logic [2:0]  FMT_J = 3'd5;
    localparam logic [31:0] NOP   = 32'h0000_0013;  // addi x0,x0,0

    // ------------------------------------------------------------------
    // Field packing and immediate legality
    // ------------------------------------------------------------------
    logic [31:0] enc_instr;
    logic        enc_err;
    logic        fits_12;
    logic        fits_13;
    logic        fits_21;

    always_comb begin
        // A signed value fits in N bits when every bit from N-1 upward
        // equals the sign, i.e. those bits are all ones or all zeros.
        fits_12   = (&in_imm[31:11]) | ~(|in_imm[31:11]);
        fits_13   = (&in_imm[31:12]) | ~(|in_imm[31:12]);
        fits_21   = (&in_imm[31:20]) | ~(|in_imm[31:20]);
        enc_instr = NOP;
        enc_err   = 1'b1;
        case (in_fmt)
            FMT_R: begin
                enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_err   = 1'b0;
            end
            FMT_I: if (fits_12) begin
                enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_err   = 1'b0;
            end
            FMT_S: if (fits_12) begin
                enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_err   = 1'b0;
            end
            // Branch/jump offsets are byte offsets to halfword targets, so
            // bit 0 is never encoded and must be clear.
            FMT_B: if (fits_13 && !in_imm[0]) begin
                enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
                enc_err   = 1'b0;
            end
            FMT_U: if (in_imm[11:0] == 12'd0) begin
                enc_instr = {in_imm[31:12], in_rd, in_opcode};
                enc_err   = 1'b0;
            end
            FMT_J: if (fits_21 && !in_imm[0]) begin
                enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                             in_rd, in_opcode};
                enc_err   = 1'b0;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register + one-entry skid buffer, address and statistics
    // ------------------------------------------------------------------
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic              out_err_q,   out_err_d;
    logic              skid_valid_q, skid_valid_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_addr_q,  skid_addr_d;
    logic              skid_err_q,   skid_err_d;
    logic              in_ready_q,   in_ready_d;
    logic [ADDR_W-1:0] addr_cnt_q,   addr_cnt_d;
    logic [CNT_W-1:0]  word_cnt_q,   word_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q,    err_cnt_d;

    logic              accept;
    logic              out_fire;
    logic              out_free;
    logic [ADDR_W-1:0] acc_addr;

    always_comb begin
        accept   = in_valid & in_ready_q;
        out_fire = out_valid_q & out_ready;
        out_free = ~out_valid_q | out_ready;
        // A load in the accept cycle addresses the accepted word itself.
        acc_addr = addr_load ? addr_val : addr_cnt_q;

        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_addr_d   = out_addr_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_addr_d  = skid_addr_q;
        skid_err_d   = skid_err_q;

        if (skid_valid_q) begin
            // in_ready is low while the skid holds a word, so nothing new
            // can arrive; just drain the skid into the output slot.
            if (out_free) begin
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr_q;
                out_addr_d   = skid_addr_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (out_free) begin
                out_valid_d = 1'b1;
                out_instr_d = enc_instr;
                out_addr_d  = acc_addr;
                out_err_d   = enc_err;
            end else begin
                skid_valid_d = 1'b1;
                skid_instr_d = enc_instr;
                skid_addr_d  = acc_addr;
                skid_err_d   = enc_err;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        in_ready_d = ~skid_valid_d;

        if (accept)
            addr_cnt_d = acc_addr + ADDR_W'(1);
        else if (addr_load)
            addr_cnt_d = addr_val;
        else
            addr_cnt_d = addr_cnt_q;

        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (out_fire && !(&word_cnt_q))
            word_cnt_d = word_cnt_q + CNT_W'(1);
        if (out_fire && out_err_q && !(&err_cnt_q))
            err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_addr_q   <= BASE_ADDR;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_addr_q  <= '0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            addr_cnt_q   <= BASE_ADDR;
            word_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_addr_q   <= out_addr_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_addr_q  <= skid_addr_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= in_ready_d;
            addr_cnt_q   <= addr_cnt_d;
            word_cnt_q   <= word_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign word_cnt  = word_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Bench for rv32i_instr_encoder: two instances (10-bit and 2-bit address)
// share all inputs; a scoreboard fed at accept time is drained by a monitor.
module tb_rv32i_instr_encoder;
    localparam int AW = 10;
    localparam logic [AW-1:0] BASE = '0;
    localparam longint P7 = 64'd128, P8 = 64'd256, P12 = 64'd4096, P15 = 64'd32768;
    localparam longint P20 = 64'd1048576, P21 = 64'd2097152, P25 = 64'd33554432;
    localparam longint P31 = 64'd2147483648;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          rst = 1'b1, addr_load = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [AW-1:0] addr_val = '0;
    logic [2:0]    in_fmt = '0, in_funct3 = '0;
    logic [6:0]    in_opcode = '0, in_funct7 = '0;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0]   in_imm = '0;

    logic          in_ready, out_valid, out_err;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic [15:0]   word_cnt, err_cnt;
    logic          in_ready2, out_valid2, out_err2;
    logic [31:0]   out_instr2;
    logic [1:0]    out_addr2;
    logic [15:0]   word_cnt2, err_cnt2;

    rv32i_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE), .CNT_W(16)) dut (
        .CLK(CLK), .rst(rst), .addr_load(addr_load), .addr_val(addr_val),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .word_cnt(word_cnt), .err_cnt(err_cnt));

    rv32i_instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'b00), .CNT_W(16)) dut2 (
        .CLK(CLK), .rst(rst), .addr_load(addr_load), .addr_val(addr_val[1:0]),
        .in_valid(in_valid), .in_ready(in_ready2), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid2), .out_ready(out_ready),
        .out_instr(out_instr2), .out_addr(out_addr2), .out_err(out_err2),
        .word_cnt(word_cnt2), .err_cnt(err_cnt2));

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    typedef struct {
        logic [31:0]   instr;
        logic [AW-1:0] addr;
        logic          err;
    } exp_t;

    exp_t        sb[$];
    bit          dexp_on = 1'b0;
    logic [31:0] dexp_instr = '0;
    bit          dexp_err = 1'b0;
    bit          hold_ready = 1'b0, rnd_ready = 1'b0;
    bit          end_req = 1'b0, final_done = 1'b0;
    int          to_cnt = 0;
    int          checks = 0, errors = 0;

    // Reference encoding from the format tables, using integer arithmetic
    // on the immediate's numeric value.
    function automatic void ref_encode(input req_t r, output logic [31:0] w, output logic e);
        longint u, v, acc, lop, lf3, lf7, lrd, lrs1, lrs2;
        bit ok;
        u = longint'(r.imm);
        v = longint'($signed(r.imm));
        lop = longint'(r.op); lf3 = longint'(r.f3); lf7 = longint'(r.f7);
        lrd = longint'(r.rd); lrs1 = longint'(r.rs1); lrs2 = longint'(r.rs2);
        ok = 1'b1;
        acc = 0;
        case (r.fmt)
            3'd0: acc = lf7*P25 + lrs2*P20 + lrs1*P15 + lf3*P12 + lrd*P7 + lop;
            3'd1: begin
                ok  = (v >= -2048) && (v <= 2047);
                acc = (u % 4096)*P20 + lrs1*P15 + lf3*P12 + lrd*P7 + lop;
            end
            3'd2: begin
                ok  = (v >= -2048) && (v <= 2047);
                acc = ((u/32) % 128)*P25 + lrs2*P20 + lrs1*P15 + lf3*P12 + (u % 32)*P7 + lop;
            end
            3'd3: begin
                ok  = (v >= -4096) && (v <= 4094) && (u % 2 == 0);
                acc = ((u/4096) % 2)*P31 + ((u/32) % 64)*P25 + lrs2*P20 + lrs1*P15 + lf3*P12
                    + ((u/2) % 16)*P8 + ((u/2048) % 2)*P7 + lop;
            end
            3'd4: begin
                ok  = (u % 4096 == 0);
                acc = u + lrd*P7 + lop;
            end
            3'd5: begin
                ok  = (v >= -1048576) && (v <= 1048574) && (u % 2 == 0);
                acc = ((u/P20) % 2)*P31 + ((u/2) % 1024)*P21 + ((u/2048) % 2)*P20
                    + ((u/4096) % 256)*P12 + lrd*P7 + lop;
            end
            default: ok = 1'b0;
        endcase
        w = ok ? acc[31:0] : 32'h0000_0013;
        e = !ok;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // out_ready driver
    initial forever begin
        @(posedge CLK); #2;
        out_ready = hold_ready ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Stimulus side of the scoreboard: record each accepted request.
    initial begin
        logic [AW-1:0] m_cnt, a;
        logic [31:0]   w;
        logic          e;
        req_t          r;
        m_cnt = BASE;
        forever begin
            @(negedge CLK);
            if (rst) begin
                m_cnt = BASE;
                sb.delete();
            end else if (in_valid && in_ready) begin
                a = addr_load ? addr_val : m_cnt;
                r = '{in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm};
                ref_encode(r, w, e);
                if (dexp_on) begin w = dexp_instr; e = dexp_err; end
                sb.push_back('{instr: w, addr: a, err: e});
                m_cnt = a + AW'(1);
            end else if (addr_load) begin
                m_cnt = addr_val;
            end
        end
    end

    // Monitor: compares outputs at handshakes and tracks occupancy/counters.
    initial begin
        int          occ, exp_word, exp_err;
        bit          rst_d, hold_v;
        logic [31:0] h_instr;
        logic [AW-1:0] h_addr;
        logic        h_err;
        exp_t        x;
        occ = 0; exp_word = 0; exp_err = 0; rst_d = 1'b0; hold_v = 1'b0;
        h_instr = '0; h_addr = '0; h_err = 1'b0;
        forever begin
            @(negedge CLK);
            if (rst_d) begin
                chk("rst in_ready", 32'(in_ready), 32'd1);
                chk("rst out_valid", 32'(out_valid), 32'd0);
                chk("rst out_instr", out_instr, 32'd0);
                chk("rst out_err", 32'(out_err), 32'd0);
                chk("rst out_addr", 32'(out_addr), 32'(BASE));
                chk("rst word_cnt", 32'(word_cnt), 32'd0);
                chk("rst err_cnt", 32'(err_cnt), 32'd0);
                chk("rst in_ready2", 32'(in_ready2), 32'd1);
                chk("rst out_valid2", 32'(out_valid2), 32'd0);
                chk("rst out_addr2", 32'(out_addr2), 32'd0);
            end
            if (rst) begin
                occ = 0; exp_word = 0; exp_err = 0; hold_v = 1'b0; rst_d = 1'b1;
            end else begin
                rst_d = 1'b0;
                chk("in_ready", 32'(in_ready), 32'(occ < 2));
                chk("out_valid", 32'(out_valid), 32'(occ > 0));
                chk("in_ready2", 32'(in_ready2), 32'(occ < 2));
                chk("out_valid2", 32'(out_valid2), 32'(occ > 0));
                chk("word_cnt", 32'(word_cnt), 32'(exp_word));
                chk("err_cnt", 32'(err_cnt), 32'(exp_err));
                chk("word_cnt2", 32'(word_cnt2), 32'(exp_word));
                chk("err_cnt2", 32'(err_cnt2), 32'(exp_err));
                if (hold_v && out_valid) begin
                    chk("stall instr", out_instr, h_instr);
                    chk("stall addr", 32'(out_addr), 32'(h_addr));
                    chk("stall err", 32'(out_err), 32'(h_err));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL pop: word %h emitted, want no word pending", out_instr);
                    end else begin
                        x = sb.pop_front();
                        chk("instr", out_instr, x.instr);
                        chk("addr", 32'(out_addr), 32'(x.addr));
                        chk("err", 32'(out_err), 32'(x.err));
                        chk("instr2", out_instr2, x.instr);
                        chk("addr2", 32'(out_addr2), 32'(x.addr[1:0]));
                        chk("err2", 32'(out_err2), 32'(x.err));
                        exp_err = exp_err + (x.err ? 1 : 0);
                    end
                    exp_word++;
                end
                hold_v  = out_valid && !out_ready;
                h_instr = out_instr; h_addr = out_addr; h_err = out_err;
                occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
            end
            if (end_req && !final_done) begin
                chk("drained", 32'(sb.size()), 32'd0);
                chk("accept timeouts", 32'(to_cnt), 32'd0);
                final_done = 1'b1;
            end
        end
    end

    task automatic send(input req_t r, input bit ld, input logic [AW-1:0] lv,
                        input bit de, input logic [31:0] di, input bit dr);
        bit acc;
        in_fmt = r.fmt; in_opcode = r.op; in_funct3 = r.f3; in_funct7 = r.f7;
        in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2; in_imm = r.imm;
        addr_load = ld; addr_val = lv;
        dexp_on = de; dexp_instr = di; dexp_err = dr;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge CLK);
            acc = in_ready;
            @(posedge CLK); #1;
        end
        if (!acc) to_cnt++;
        in_valid = 1'b0; addr_load = 1'b0; dexp_on = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; addr_load = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; addr_load = 1'b0;
        repeat (2) @(posedge CLK);
        #1 rst = 1'b0;
    endtask

    function automatic req_t rand_req();
        req_t r;
        int bv [14] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                        1048574, 1048576, -1048576, -1048578, -2};
        r.fmt = 3'($urandom_range(0, 7));
        r.op  = 7'($urandom); r.f3 = 3'($urandom); r.f7 = 7'($urandom);
        r.rd  = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
        case ($urandom_range(0, 4))
            0: r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1: r.imm = 32'($urandom);
            2: r.imm = 32'($urandom) & 32'hFFFF_F000;
            3: r.imm = 32'(bv[$urandom_range(0, 13)]);
            default: r.imm = (32'($urandom_range(0, 4194303)) - 32'd2097152) & ~32'd1;
        endcase
        return r;
    endfunction

    req_t        dreq [10];
    logic [31:0] dins [10];
    bit          dre  [10];

    initial begin
        dreq[0] = '{3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5};        dins[0] = 32'h0050_0093; dre[0] = 0;
        dreq[1] = '{3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0};        dins[1] = 32'h0020_81B3; dre[1] = 0;
        dreq[2] = '{3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8};        dins[2] = 32'h0020_A423; dre[2] = 0;
        dreq[3] = '{3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000}; dins[3] = 32'h1234_52B7; dre[3] = 0;
        dreq[4] = '{3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC}; dins[4] = 32'hFE00_0EE3; dre[4] = 0;
        dreq[5] = '{3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048};     dins[5] = 32'h0010_00EF; dre[5] = 0;
        dreq[6] = '{3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3};        dins[6] = 32'h0000_0013; dre[6] = 1;
        dreq[7] = '{3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048};     dins[7] = 32'h0000_0013; dre[7] = 1;
        dreq[8] = '{3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0};        dins[8] = 32'h0000_0013; dre[8] = 1;
        dreq[9] = '{3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800}; dins[9] = 32'h8000_0093; dre[9] = 0;

        do_reset();
        // Known-answer vectors, full throughput.
        for (int i = 0; i < 10; i++) send(dreq[i], 1'b0, '0, 1'b1, dins[i], dre[i]);
        idle(4);

        // Backpressure: 3-cycle consumer stall in the middle of 6 requests.
        do_reset();
        for (int i = 0; i < 2; i++) send(rand_req(), 1'b0, '0, 1'b0, '0, 1'b0);
        fork
            begin hold_ready = 1'b1; repeat (3) @(posedge CLK); hold_ready = 1'b0; end
        join_none
        for (int i = 0; i < 4; i++) send(rand_req(), 1'b0, '0, 1'b0, '0, 1'b0);
        idle(6);

        // Reset while the skid holds a word.
        fork
            begin hold_ready = 1'b1; repeat (8) @(posedge CLK); hold_ready = 1'b0; end
        join_none
        for (int i = 0; i < 2; i++) send(rand_req(), 1'b0, '0, 1'b0, '0, 1'b0);
        idle(1);
        rst = 1'b1;
        @(posedge CLK); #1 rst = 1'b0;
        idle(8);

        // Address wrap (2-bit instance) and counter loads.
        for (int i = 0; i < 5; i++) send(rand_req(), 1'b0, '0, 1'b0, '0, 1'b0);
        send(rand_req(), 1'b1, AW'(2), 1'b0, '0, 1'b0);
        send(rand_req(), 1'b0, '0, 1'b0, '0, 1'b0);
        send(rand_req(), 1'b1, AW'(1022), 1'b0, '0, 1'b0);
        for (int i = 0; i < 2; i++) send(rand_req(), 1'b0, '0, 1'b0, '0, 1'b0);
        addr_load = 1'b1; addr_val = AW'(500);
        @(posedge CLK); #1 addr_load = 1'b0;
        send(rand_req(), 1'b0, '0, 1'b0, '0, 1'b0);
        idle(3);

        // Randomized traffic with random consumer readiness.
        rnd_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if (i == 200) do_reset();
            send(rand_req(), ($urandom_range(0, 19) == 0), AW'($urandom), 1'b0, '0, 1'b0);
        end
        rnd_ready = 1'b0;
        for (int k = 0; k < 200 && sb.size() != 0; k++) idle(1);
        idle(2);

        end_req = 1'b1;
        for (int k = 0; k < 10 && !final_done; k++) @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
